// File: rtl/level_sequencer_if.sv
// Game-sequencer bundle: controller/verifier/timer events in, countdown/keygen/status out.
// master drives the events, slave is the sequencer.
interface level_sequencer_if;
    logic        start;
    logic        result_valid;
    logic        result_pass;
    logic        timeout;
    logic [11:0] init_time;
    logic        load_time;
    logic        keygen_req;
    logic [3:0]  cur_level;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        game_over;
    logic        game_won;
    logic [2:0]  seq_state;

    modport master (
        output start, result_valid, result_pass, timeout,
        input  init_time, load_time, keygen_req, cur_level, score, lives,
               game_over, game_won, seq_state
    );

    modport slave (
        input  start, result_valid, result_pass, timeout,
        output init_time, load_time, keygen_req, cur_level, score, lives,
               game_over, game_won, seq_state
    );
endinterface

// File: rtl/level_sequencer.sv
// Game-level scheduler: levels, lives, score, countdown preset and key requests.
// start -> LOAD strobes next cycle -> PLAY the cycle after; all outputs registered, no backpressure.
module level_sequencer #(
    parameter int NUM_LEVELS  = 8,
    parameter int BASE_TIME   = 60,
    parameter int TIME_STEP   = 5,
    parameter int MIN_TIME    = 20,
    parameter int START_LIVES = 3
) (
    input  logic              clk,
    input  logic              rst,
    level_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PLAY    = 3'd2,
        S_ADVANCE = 3'd3,
        S_PENALTY = 3'd4,
        S_LOST    = 3'd5,
        S_WON     = 3'd6
    } state_t;

    localparam logic signed [15:0] BASE_S = 16'(BASE_TIME);
    localparam logic signed [15:0] STEP_S = 16'(TIME_STEP);
    localparam logic signed [15:0] MIN_S  = 16'(MIN_TIME);

    state_t             state_q, state_nxt;
    logic [3:0]         level_q, level_nxt;
    logic [7:0]         score_q, score_nxt;
    logic [1:0]         lives_q, lives_nxt;
    logic [11:0]        init_time_q, init_time_nxt;
    logic               load_q, over_q, won_q;
    logic signed [15:0] secs_raw, secs_clamped;
    logic [9:0]         secs_bin;
    logic [8:0]         score_sum;

    // Countdown preset is derived from the level being entered, so it is ready in the LOAD cycle.
    always_comb begin
        secs_raw      = BASE_S - ($signed({12'd0, level_nxt}) - 16'sd1) * STEP_S;
        secs_clamped  = (secs_raw < MIN_S) ? MIN_S : secs_raw;
        secs_bin      = 10'(secs_clamped);
        init_time_nxt = {4'(secs_bin / 10'd100),
                         4'((secs_bin / 10'd10) % 10'd10),
                         4'(secs_bin % 10'd10)};
    end

    assign score_sum = {1'b0, score_q} + 9'({5'd0, level_q} * 9'd10);

    always_comb begin
        state_nxt = state_q;
        level_nxt = level_q;
        score_nxt = score_q;
        lives_nxt = lives_q;
        case (state_q)
            S_IDLE, S_LOST, S_WON: begin
                if (bus.start) begin
                    level_nxt = 4'd1;
                    score_nxt = 8'd0;
                    lives_nxt = 2'(START_LIVES);
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_PLAY;
            S_PLAY: begin
                // A pass wins over a coincident timeout.
                if (bus.result_valid && bus.result_pass) begin
                    state_nxt = S_ADVANCE;
                end else if (bus.result_valid) begin
                    state_nxt = S_PENALTY;
                end else if (bus.timeout) begin
                    lives_nxt = 2'd0;
                    state_nxt = S_LOST;
                end
            end
            S_ADVANCE: begin
                score_nxt = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
                if (level_q == 4'(NUM_LEVELS)) begin
                    state_nxt = S_WON;
                end else begin
                    level_nxt = level_q + 4'd1;
                    state_nxt = S_LOAD;
                end
            end
            S_PENALTY: begin
                lives_nxt = lives_q - 2'd1;
                state_nxt = (lives_q == 2'd1) ? S_LOST : S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            level_q     <= 4'd0;
            score_q     <= 8'd0;
            lives_q     <= 2'd0;
            init_time_q <= 12'h000;
            load_q      <= 1'b0;
            over_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q <= state_nxt;
            level_q <= level_nxt;
            score_q <= score_nxt;
            lives_q <= lives_nxt;
            load_q  <= (state_nxt == S_LOAD);
            over_q  <= (state_nxt == S_LOST);
            won_q   <= (state_nxt == S_WON);
            if (state_nxt == S_LOAD) begin
                init_time_q <= init_time_nxt;
            end
        end
    end

    assign bus.seq_state  = state_q;
    assign bus.cur_level  = level_q;
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.init_time  = init_time_q;
    assign bus.load_time  = load_q;
    assign bus.keygen_req = load_q;
    assign bus.game_over  = over_q;
    assign bus.game_won   = won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Randomized game sessions against a game-rule model; a second instance with a larger
// time step shares the stimulus so the countdown floor is exercised.
module tb_level_sequencer;
    localparam int NL = 8;
    localparam int BT = 60;
    localparam int MT = 20;
    localparam int SL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    level_sequencer_if bus_a ();
    level_sequencer_if bus_b ();

    assign bus_b.start        = bus_a.start;
    assign bus_b.result_valid = bus_a.result_valid;
    assign bus_b.result_pass  = bus_a.result_pass;
    assign bus_b.timeout      = bus_a.timeout;

    level_sequencer #(.NUM_LEVELS(NL), .BASE_TIME(BT), .TIME_STEP(5), .MIN_TIME(MT),
                      .START_LIVES(SL)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    level_sequencer #(.NUM_LEVELS(NL), .BASE_TIME(BT), .TIME_STEP(10), .MIN_TIME(MT),
                      .START_LIVES(SL)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;
    int m_lvl, m_score, m_lives, m_st;

    function automatic int exp_secs(int lvl, int step);
        int t;
        t = BT - (lvl - 1) * step;
        return (t < MT) ? MT : t;
    endfunction

    function automatic logic [11:0] bcd(int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic st, logic rv, logic rp, logic to);
        bus_a.start        = st;
        bus_a.result_valid = rv;
        bus_a.result_pass  = rp;
        bus_a.timeout      = to;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of arbitrary inputs in a state where all of them must be ignored.
    task automatic noise_tick();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        tick();
        drive(0, 0, 0, 0);
    endtask

    task automatic check_all(string tag, int st);
        chk({tag, ":state"}, 32'(bus_a.seq_state), 32'(st));
        chk({tag, ":state_b"}, 32'(bus_b.seq_state), 32'(st));
        chk({tag, ":level"}, 32'(bus_a.cur_level), 32'(m_lvl));
        chk({tag, ":score"}, 32'(bus_a.score), 32'(m_score));
        chk({tag, ":lives"}, 32'(bus_a.lives), 32'(m_lives));
        chk({tag, ":load_time"}, 32'(bus_a.load_time), 32'(st == 1));
        chk({tag, ":keygen"}, 32'(bus_a.keygen_req), 32'(st == 1));
        chk({tag, ":over"}, 32'(bus_a.game_over), 32'(st == 5));
        chk({tag, ":won"}, 32'(bus_a.game_won), 32'(st == 6));
    endtask

    task automatic load_then_play();
        check_all("load", 1);
        chk("load:init_a", 32'(bus_a.init_time), 32'(bcd(exp_secs(m_lvl, 5))));
        chk("load:init_b", 32'(bus_b.init_time), 32'(bcd(exp_secs(m_lvl, 10))));
        noise_tick();
        check_all("play", 2);
        chk("play:init_a", 32'(bus_a.init_time), 32'(bcd(exp_secs(m_lvl, 5))));
        chk("play:init_b", 32'(bus_b.init_time), 32'(bcd(exp_secs(m_lvl, 10))));
    endtask

    initial begin
        int pct, r, kind;
        bit in_game;
        drive(0, 0, 0, 0);
        m_lvl = 0; m_score = 0; m_lives = 0; m_st = 0;
        repeat (3) tick();
        check_all("reset", 0);
        chk("reset:init_a", 32'(bus_a.init_time), 32'h0);
        rst = 1'b0;
        tick();
        check_all("idle", 0);

        for (int g = 0; g < 30; g++) begin
            repeat ($urandom_range(0, 3)) begin
                drive(0, 1'($urandom), 1'($urandom), 1'($urandom));
                tick();
                check_all("hold", m_st);
            end
            drive(1, 0, 0, 0);
            tick();
            drive(0, 0, 0, 0);
            m_lvl = 1; m_score = 0; m_lives = SL;
            load_then_play();
            pct = (g % 3 == 0) ? 95 : ((g % 3 == 1) ? 80 : 55);
            in_game = 1'b1;
            while (in_game) begin
                repeat ($urandom_range(0, 3)) begin
                    drive(1'($urandom), 0, 1'($urandom), 0);
                    tick();
                    drive(0, 0, 0, 0);
                    check_all("play_idle", 2);
                end
                if (g == 4 && m_lvl == 3) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    m_lvl = 0; m_score = 0; m_lives = 0; m_st = 0;
                    check_all("rst_play", 0);
                    chk("rst_play:init_a", 32'(bus_a.init_time), 32'h0);
                    chk("rst_play:init_b", 32'(bus_b.init_time), 32'h0);
                    in_game = 1'b0;
                    continue;
                end
                if (g == 0) kind = 0;
                else if (g == 1) kind = (m_lvl == 1) ? 0 : 1;
                else begin
                    r = int'($urandom_range(0, 99));
                    kind = (r < pct) ? 0 : ((r < pct + (100 - pct) * 2 / 3) ? 1 : 2);
                end
                if (kind == 0) begin
                    drive(0, 1, 1, 1'($urandom));
                    tick();
                    drive(0, 0, 0, 0);
                    check_all("adv", 3);
                    noise_tick();
                    m_score = (m_score + m_lvl * 10 > 255) ? 255 : m_score + m_lvl * 10;
                    if (m_lvl == NL) begin
                        m_st = 6;
                        check_all("won", 6);
                        in_game = 1'b0;
                    end else begin
                        m_lvl++;
                        load_then_play();
                    end
                end else if (kind == 1) begin
                    drive(0, 1, 0, 1'($urandom));
                    tick();
                    drive(0, 0, 0, 0);
                    check_all("pen", 4);
                    noise_tick();
                    m_lives--;
                    if (m_lives == 0) begin
                        m_st = 5;
                        check_all("lost_pen", 5);
                        in_game = 1'b0;
                    end else begin
                        load_then_play();
                    end
                end else begin
                    drive(0, 0, 1'($urandom), 1);
                    tick();
                    drive(0, 0, 0, 0);
                    m_lives = 0;
                    m_st = 5;
                    check_all("lost_tmo", 5);
                    in_game = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
